alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 16-bit registered ALU between NREQ independent requesters.
//  Round-robin arbiter with valid/ready request ports and one tagged response channel.
//  Sequences each operation through the ALU's one-cycle registered latency.
//  Sits between decode/issue clients and the ALU datapath; owns ALU operand/op drive.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  IDW   2   requester-id width; must satisfy 2**IDW >= NREQ
//  W     16  data width; fixed to ALU width
// PORTS
//  clk          in   1        clock; all state updates on posedge
//  rst          in   1        asynchronous, active-low reset
//  req_valid    in   NREQ     per-requester request valid
//  req_ready    out  NREQ     per-requester accept; one-hot or zero
//  req_a        in   NREQ*W   operand A, requester i at bits [i*W +: W]
//  req_b        in   NREQ*W   operand B, same packing
//  req_op       in   NREQ*4   4-bit ALU opcode, requester i at [i*4 +: 4]
//  alu_a        out  W        registered operand A to ALU
//  alu_b        out  W        registered operand B to ALU
//  alu_op       out  4        registered opcode to ALU
//  alu_result   in   W        ALU registered result
//  resp_valid   out  1        response valid
//  resp_ready   in   1        response accepted by consumer
//  resp_id      out  IDW      id of requester owning the response
//  resp_result  out  W        captured result
//  resp_err     out  1        1 = opcode not supported; resp_result forced 0
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; RR pointer = NREQ-1, so requester 0 has top priority.
//  - Reset mid-operation aborts silently; no response is produced for the in-flight request.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. One operation in flight at a time.
//  - IDLE: grant = first req_valid[i] scanning from ptr+1 (mod NREQ).
//    req_ready[grant] = 1 combinationally, only in IDLE. Other req_ready bits stay 0.
//    On accept edge: latch a/b/op into alu_*; latch id; ptr <= grant; go to ISSUE.
//  - ISSUE: ALU samples alu_* at the end of this cycle. Go to WAIT.
//  - WAIT: alu_result is valid. Capture it into resp_result. Go to RESP.
//  - RESP: resp_valid = 1; id/result/err stay stable until resp_valid & resp_ready.
//    On handshake: go to IDLE. The next grant is possible in the following IDLE cycle.
//  - Latency: resp_valid rises after the 2nd posedge following the accept edge.
//    Minimum issue interval is 4 cycles when resp_ready is held 1.
//  - No valid requests in IDLE: stay in IDLE; alu_* hold their last values; ptr unchanged.
//  - Requesters must hold a/b/op stable while valid and not ready.
//    The arbiter samples them only on the accept edge.
//  - Supported opcodes: 0000 ADD, 0001 SUB, 0010 SRA, 0011 ROL,
//    1000 AND, 1001 OR, 1010 XOR, 1011 NOT, 1100 SLL, 1101 SRL.
//  - Unsupported opcode: latency unchanged (ISSUE/WAIT still traversed).
//    alu_op is driven to ADD with alu_a = alu_b = 0.
//    Response gives resp_err = 1 and resp_result = 0.
//  - Arithmetic is mod 2**W; the arbiter never inspects or alters the result for supported ops.
//  - Fairness: a continuously-asserted requester waits at most NREQ-1 grants.
//  - The ALU shares clk/rst with this block; no other agent drives alu_*.
// STRUCTURE
//  - Shared include alu_defs.vh: opcode localparams, op_supported function,
//    FSM state encodings (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3).
//  - Sub-module rr_pick (NREQ, IDW): combinational round-robin.
//    Inputs req vector and ptr; outputs one-hot grant, grant id, any.
//  - Top: FSM, operand mux and registers, response registers, ptr register.
// TESTING
//  - Req0 ADD a=3 b=5 alone, resp_ready=1 -> resp_id=0, resp_result=8, err=0.
//    resp_valid is high after the 2nd edge following accept.
//  - Req1 SUB a=0 b=1 -> resp_result=16'hFFFF (wrap), err=0.
//  - All 4 valid continuously from reset -> grant order 0,1,2,3,0.
//    req_ready is always one-hot in IDLE and zero elsewhere.
//  - resp_ready low 5 cycles in RESP -> resp_* stable, req_ready=0 throughout.
//    Release -> one handshake, then the next grant.
//  - Req2 op=4'b0111 a=9 b=9 -> resp_err=1, resp_result=0, resp_id=2.
//    alu_op=ADD and alu_a=alu_b=0 during the op.
//  - Assert rst low in WAIT -> all outputs 0 immediately; no response after release.
//    Req3 and req0 both valid -> req0 granted first.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode set, opcode legality check and arbiter FSM encodings.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SRA = 4'b0010;
    localparam logic [3:0] OP_ROL = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;
    localparam logic [3:0] OP_SLL = 4'b1100;
    localparam logic [3:0] OP_SRL = 4'b1101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // True when the ALU implements this opcode.
    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SRA, OP_ROL,
            OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SLL, OP_SRL: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request after ptr (mod NREQ).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a pick is consumed.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // Walk offsets 1..NREQ from the last winner so the last winner has lowest priority.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!any && req[j] && (j == (int'(ptr) + k) % NREQ)) begin
                    any    = 1'b1;
                    gnt[j] = 1'b1;
                    gnt_id = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered 16-bit ALU between NREQ requesters, one op in flight.
// Latency: resp_valid rises after the 2nd posedge following the accept edge; 4-cycle issue interval.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready, blocking new grants.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_op,
    input  logic [W-1:0]      alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_result,
    output logic              resp_err
);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic            accept;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [3:0]      sel_op;
    logic            sel_ok;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    assign accept     = (state == ST_IDLE) && gnt_any;
    // Gated by rst so every output reads 0 while reset is held, even with requests pending.
    assign req_ready  = ((state == ST_IDLE) && rst) ? gnt : '0;
    assign resp_valid = (state == ST_RESP);

    // Select the granted requester's operands and classify its opcode.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt[j]) begin
                sel_a  = req_a[j*W +: W];
                sel_b  = req_b[j*W +: W];
                sel_op = req_op[j*4 +: 4];
            end
        end
        sel_ok = op_supported(sel_op);
    end

    // Sequence one operation: accept, let the ALU sample, capture, hand back.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (gnt_any) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_RESP;
            ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // ALU drive: unsupported ops become a harmless ADD of zeros so latency is unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= OP_ADD;
        end else if (accept) begin
            alu_a  <= sel_ok ? sel_a  : '0;
            alu_b  <= sel_ok ? sel_b  : '0;
            alu_op <= sel_ok ? sel_op : OP_ADD;
        end
    end

    // Winner bookkeeping: RR pointer, owning id and error flag, all latched on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= IDW'(NREQ - 1);
            resp_id  <= '0;
            resp_err <= 1'b0;
        end else if (accept) begin
            ptr      <= gnt_id;
            resp_id  <= gnt_id;
            resp_err <= !sel_ok;
        end
    end

    // Capture the ALU result in WAIT; errored ops report 0 regardless of the ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  resp_result <= '0;
        else if (state == ST_WAIT) resp_result <= resp_err ? '0 : alu_result;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU stand-in, transaction-level model, per-cycle compare.
// Latency: n/a.
// Backpressure: resp_ready driven directly by the directed sequence.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic [W-1:0]      alu_a, alu_b, alu_result;
    logic [3:0]        alu_op;
    logic              resp_valid, resp_ready, resp_err;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_result;

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        logic signed [15:0] sa;
        logic [31:0]        dbl;
        sa  = a;
        dbl = {a, a} << b[3:0];
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return 16'(sa >>> b[3:0]);
            4'h3:    return dbl[31:16];
            4'h8:    return a & b;
            4'h9:    return a | b;
            4'hA:    return a ^ b;
            4'hB:    return ~a;
            4'hC:    return a << b[3:0];
            4'hD:    return a >> b[3:0];
            default: return 16'h0;
        endcase
    endfunction

    // Registered ALU stand-in sharing clk/rst with the arbiter.
    always @(posedge clk or negedge rst) begin
        if (!rst) alu_result <= '0;
        else      alu_result <= alu_f(alu_a, alu_b, alu_op);
    end

    // ---------------- transaction-level model ----------------
    int          m_last;
    bit          m_busy;
    int          m_age;
    int          m_id;
    logic [15:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    bit          m_err;
    int          acc_log[$];

    function automatic int next_grant(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit supp(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
    endfunction

    always @(posedge clk or negedge rst) begin
        int g;
        logic [15:0] a, b;
        logic [3:0]  op;
        if (!rst) begin
            m_last = NREQ - 1;
            m_busy = 0;
            m_age  = 0;
        end else if (!m_busy) begin
            g = next_grant(req_valid, m_last);
            if (g >= 0) begin
                a      = req_a[g*W +: W];
                b      = req_b[g*W +: W];
                op     = req_op[g*4 +: 4];
                m_err  = !supp(op);
                m_a    = m_err ? 16'h0 : a;
                m_b    = m_err ? 16'h0 : b;
                m_op   = m_err ? 4'h0 : op;
                m_res  = m_err ? 16'h0 : alu_f(a, b, op);
                m_id   = g;
                m_last = g;
                m_busy = 1;
                m_age  = 0;
                acc_log.push_back(g);
            end
        end else if (m_age == 2) begin
            if (resp_ready) m_busy = 0;
        end else begin
            m_age++;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        if (!rst) begin
            chk("reset_outputs", {req_ready, resp_valid, resp_id, resp_result, resp_err, alu_a, alu_b, alu_op}, 64'h0);
        end else begin
            exp_rdy = '0;
            if (!m_busy) begin
                g = next_grant(req_valid, m_last);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rdy);
            chk("resp_valid", resp_valid, (m_busy && m_age == 2));
            if (m_busy) chk("alu_drive", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
            if (m_busy && m_age == 2)
                chk("resp_fields", {resp_id, resp_err, resp_result}, {IDW'(m_id), m_err, m_res});
        end
    end

    // Requesters drop valid the cycle after their handshake when auto_drop is set.
    bit              auto_drop = 0;
    logic [NREQ-1:0] hs_snap = '0;
    always @(negedge clk) hs_snap = req_valid & req_ready;
    always @(posedge clk) begin
        if (auto_drop) begin
            #1;
            req_valid = req_valid & ~hs_snap;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*4 +: 4] = op;
        req_valid[i] = 1'b1;
    endtask

    // Wait (bounded) for resp_valid at a negedge; returns number of negedges waited.
    task automatic wait_resp(output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n++;
            if (resp_valid) break;
        end
        if (!resp_valid) chk("resp_timeout", 1, 0);
    endtask

    task automatic run_case(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_res, input bit exp_err);
        int lat;
        set_req(i, a, b, op);
        wait_resp(lat);
        chk($sformatf("latency_r%0d", i), lat, 4);
        chk($sformatf("id_r%0d", i), resp_id, i);
        chk($sformatf("result_r%0d_op%0h", i, op), resp_result, exp_res);
        chk($sformatf("err_r%0d_op%0h", i, op), resp_err, exp_err);
        if (exp_err) chk("err_alu_drive", {alu_op, alu_a, alu_b}, 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        resp_ready = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;

        // All four requesting continuously from reset: grants 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 1), 16'(10 * i), 4'h0);
        repeat (2) @(negedge clk);
        chk("ready_in_reset", req_ready, 0);
        #1 rst = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (acc_log.size() >= 5) break;
        end
        req_valid = '0;
        chk("rr_count", acc_log.size(), 5);
        if (acc_log.size() >= 5) begin
            chk("rr_g0", acc_log[0], 0);
            chk("rr_g1", acc_log[1], 1);
            chk("rr_g2", acc_log[2], 2);
            chk("rr_g3", acc_log[3], 3);
            chk("rr_g4", acc_log[4], 0);
        end
        repeat (6) @(posedge clk);
        #1;

        // Single requests with hand-computed results.
        auto_drop = 1;
        run_case(0, 4'h0, 16'd3,    16'd5,  16'd8,    1'b0);
        run_case(1, 4'h1, 16'd0,    16'd1,  16'hFFFF, 1'b0);
        run_case(3, 4'h2, 16'h8000, 16'd4,  16'hF800, 1'b0);
        run_case(0, 4'h3, 16'h8001, 16'd1,  16'h0003, 1'b0);
        run_case(2, 4'hB, 16'h00F0, 16'd0,  16'hFF0F, 1'b0);
        run_case(1, 4'hD, 16'h8000, 16'd15, 16'h0001, 1'b0);

        // Held response: resp stable and no grants while resp_ready is low.
        acc_log.delete();
        resp_ready = 1'b0;
        set_req(1, 16'd1, 16'd1, 4'h0);
        set_req(2, 16'd2, 16'd2, 4'h0);
        wait_resp(n);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("held_resp", {resp_valid, resp_id, resp_result}, {1'b1, 2'd2, 16'd4});
            chk("held_ready", req_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        wait_resp(n);
        chk("after_release_id", resp_id, 1);
        chk("after_release_res", resp_result, 2);
        chk("held_order", acc_log.size() == 2 && acc_log[0] == 2 && acc_log[1] == 1, 1);
        @(posedge clk); #1;

        // Unsupported opcode.
        run_case(2, 4'b0111, 16'd9, 16'd9, 16'h0000, 1'b1);

        // Reset during WAIT aborts; afterwards requester 0 beats requester 3.
        set_req(3, 16'd7, 16'd7, 4'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[3]) break;
        end
        chk("r3_ready", req_ready[3], 1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_now", {req_ready, resp_valid, resp_id, resp_result, resp_err, alu_a, alu_b, alu_op}, 64'h0);
        acc_log.delete();
        set_req(0, 16'd4, 16'd6, 4'h0);
        set_req(3, 16'd7, 16'd7, 4'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        wait_resp(n);
        chk("post_reset_first_id", resp_id, 0);
        chk("post_reset_first_res", resp_result, 10);
        @(posedge clk); #1;
        wait_resp(n);
        chk("post_reset_second_id", resp_id, 3);
        chk("post_reset_second_res", resp_result, 14);
        @(posedge clk); #1;
        chk("post_reset_order", acc_log.size() == 2 && acc_log[0] == 0 && acc_log[1] == 3, 1);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
